mips_data_memory: RTL and testbench
===================================

# mips_data_memory

Word-organised data memory for the MIPS single-cycle datapath, sitting after the ALU in the MEM stage. It takes a byte address from the ALU result, returns a 32-bit word on loads (`lw`), and stores a 32-bit word on stores (`sw`). Reset reloads a known initial image so programs and benches start from deterministic contents.

## Interface
Parameters:
- `DEPTH`, 256, number of 32-bit words; power of two, at least 8.
- `AW`, log2(`DEPTH`), word-index width.

Ports (`data_memory` keeps this order after `clk`; positional instantiation relies on it):
- `clk`  input  1  single clock; all writes occur on its rising edge.
- `rst`  input  1  asynchronous, active-low reset.
- `addr`  input  32  byte address.
- `MemWrite`  input  1  write enable.
- `MemRead`  input  1  read enable.
- `writedata`  input  32  store data.
- `readdata`  output  32  load data.

## Operation
- Storage is `mem[0..DEPTH-1]`, 32 bits per word.
- Word index is `addr[AW+1:2]`.
  - `addr[1:0]` is ignored, so misaligned addresses round down to the word.
  - `addr[31:AW+2]` is ignored, so out-of-range addresses wrap modulo `DEPTH`.
- Reset: while `rst`=0, every `mem[i]` is loaded with `i`, zero-extended to 32 bits. This happens immediately, without waiting for a clock edge.
  - Example: `mem[4]`=4.
  - Writes are blocked while `rst`=0.
- Write: at the rising edge of `clk`, if `rst`=1 and `MemWrite`=1, then `mem[index]` takes `writedata`.
- Read: combinational.
  - `readdata` = `mem[index]` when `rst`=1 and `MemRead`=1.
  - Otherwise `readdata` = 32'd0.
- `MemRead` and `MemWrite` both 1: the write occurs at the edge. Before the edge `readdata` shows the old word; after the edge, in the same cycle, it shows the new word.
- X or undriven `MemWrite` must not corrupt memory. Treat the write condition as "`MemWrite` === 1".
- No byte or halfword enables. Full-word accesses only.

## Timing
- Reset is asynchronous.
  - Assertion clears `readdata` to 0 and loads the init image within the same timestep.
  - Deassertion has effect at the next edge.
- Write latency: one `clk` rising edge.
- Read latency: zero cycles, combinational from `addr`, `MemRead`, `rst` and memory contents.
- Read-after-write to the same word returns new data as soon as the write edge has passed.
- Reset asserted mid-operation: any pending write at a later edge is discarded. Contents revert to the init image regardless of prior writes.
- Reset value of outputs: `readdata`=0.

## Test plan
- Reset load: `rst`=0 for 2 cycles, release, `MemRead`=1, `addr`=16 -> `readdata`=4. Then `addr`=0 -> 0, `addr`=1020 -> 255.
- Write then read: `MemWrite`=1, `MemRead`=0, `addr`=16, `writedata`=97, one edge. Then `MemWrite`=0, `MemRead`=1 -> `readdata`=97. `addr`=20 is unchanged at 5.
- Read gating and alignment:
  - `MemRead`=0 on any address -> `readdata`=0.
  - `addr`=19, `MemRead`=1 -> same word as `addr`=16.
  - `addr`=16+4·`DEPTH` -> aliases to word 4.
- Simultaneous read/write: `MemRead`=1, `MemWrite`=1, `addr`=8, `writedata`=32'hDEADBEEF -> `readdata`=2 before the edge, 32'hDEADBEEF after it.
- Reset mid-operation: write 123 to word 7, then assert `rst`=0 between edges -> `readdata`=0 immediately. A `MemWrite` pulse during reset has no effect. After release, word 7 reads 7.
- Randomised: 1000 mixed read/write cycles against a reference array model, compared every cycle with 100% match.

Source files
------------

// File: rtl/mips_data_memory.sv
// Word-organised data memory for the MIPS single-cycle datapath (MEM stage).
// Combinational reads, rising-edge writes, async active-low reset to an index image.
module mips_data_memory #(
   parameter int unsigned DEPTH = 256,
   parameter int unsigned AW    = $clog2(DEPTH)
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] addr,
   input  logic        MemWrite,
   input  logic        MemRead,
   input  logic [31:0] writedata,
   output logic [31:0] readdata
);

   logic [31:0]   mem_q [DEPTH];
   logic [AW-1:0] idx;
   logic          wr_en;
   logic          unused_addr;

   // Byte offset and high address bits are dropped: misaligned rounds down, out-of-range wraps.
   assign idx         = addr[AW+1:2];
   assign unused_addr = ^{addr[31:AW+2], addr[1:0]};

   // An X or floating write strobe must never be taken as a write.
   assign wr_en = (MemWrite === 1'b1);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int unsigned i = 0; i < DEPTH; i++) begin
            mem_q[i] <= 32'(i);
         end
      end else if (wr_en) begin
         mem_q[idx] <= writedata;
      end
   end

   always_comb begin
      readdata = '0;
      if (rst && MemRead) begin
         readdata = mem_q[idx];
      end
   end

endmodule

// File: tb/tb_mips_data_memory.sv
// Scoreboard bench for mips_data_memory: stimulus pushes expectations computed
// from a word-array reference model; a monitor process pops and compares.
module tb_mips_data_memory;

   localparam int unsigned DEPTH = 256;

   logic        clk;
   logic        rst;
   logic [31:0] addr;
   logic        MemWrite;
   logic        MemRead;
   logic [31:0] writedata;
   logic [31:0] readdata;

   mips_data_memory #(.DEPTH(DEPTH)) dut (
      .clk      (clk),
      .rst      (rst),
      .addr     (addr),
      .MemWrite (MemWrite),
      .MemRead  (MemRead),
      .writedata(writedata),
      .readdata (readdata)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      string       name;
      logic [31:0] exp;
   } exp_t;

   exp_t        exp_q[$];
   event        check_ev;
   int          n_tests = 0;
   int          n_fail  = 0;
   logic [31:0] ref_mem [DEPTH];

   function automatic int unsigned widx(input logic [31:0] a);
      return (a / 4) % DEPTH;
   endfunction

   task automatic model_reset();
      for (int i = 0; i < DEPTH; i++) ref_mem[i] = i;
   endtask

   task automatic check(input string name);
      exp_t e;
      e.name = name;
      e.exp  = (rst === 1'b1 && MemRead === 1'b1) ? ref_mem[widx(addr)] : 32'd0;
      exp_q.push_back(e);
      ->check_ev;
      #1;
   endtask

   task automatic drive(input logic [31:0] a, input logic we, input logic re,
                        input logic [31:0] wd);
      @(negedge clk);
      addr      = a;
      MemWrite  = we;
      MemRead   = re;
      writedata = wd;
      #1;
   endtask

   task automatic tick();
      @(posedge clk);
      if (rst === 1'b1 && MemWrite === 1'b1) ref_mem[widx(addr)] = writedata;
      #1;
   endtask

   // Monitor: compares DUT output against each queued expectation.
   initial begin
      exp_t e;
      forever begin
         @check_ev;
         while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_tests++;
            if (readdata !== e.exp) begin
               n_fail++;
               $display("FAIL %s: readdata=%h expected=%h (addr=%h we=%b re=%b rst=%b)",
                        e.name, readdata, e.exp, addr, MemWrite, MemRead, rst);
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] a;
      rst = 1'b0; addr = 32'd16; MemWrite = 1'b0; MemRead = 1'b1; writedata = '0;
      model_reset();
      #1;
      check("reset_out_zero");
      repeat (2) @(posedge clk);
      drive(32'd16, 1'b0, 1'b1, 32'd0);
      rst = 1'b1;
      #1;
      check("reset_img_16");
      drive(32'd0, 1'b0, 1'b1, 32'd0);    check("reset_img_0");
      drive(32'd1020, 1'b0, 1'b1, 32'd0); check("reset_img_1020");

      drive(32'd16, 1'b1, 1'b0, 32'd97);  check("write_noread");
      tick();
      drive(32'd16, 1'b0, 1'b1, 32'd0);   check("read_after_write");
      drive(32'd20, 1'b0, 1'b1, 32'd0);   check("neighbour_unchanged");

      drive(32'd20, 1'b0, 1'b0, 32'd0);   check("read_gated");
      drive(32'd19, 1'b0, 1'b1, 32'd0);   check("misaligned_19");
      drive(32'd16 + 4 * DEPTH, 1'b0, 1'b1, 32'd0); check("alias_wrap");
      drive(32'hFFFF_FC10, 1'b0, 1'b1, 32'd0);      check("alias_high");

      drive(32'd8, 1'b1, 1'b1, 32'hDEAD_BEEF); check("rw_before_edge");
      tick();                                  check("rw_after_edge");

      drive(32'd28, 1'b1, 1'b0, 32'd123); tick();
      drive(32'd28, 1'b0, 1'b1, 32'd0);   check("word7_written");
      #2;
      rst = 1'b0;
      model_reset();
      #1;
      check("mid_reset_immediate");
      MemWrite = 1'b1; writedata = 32'hCAFE_F00D;
      tick();
      check("write_during_reset");
      drive(32'd28, 1'b0, 1'b1, 32'd0);
      rst = 1'b1;
      #1;
      check("word7_reverted");
      drive(32'd8, 1'b0, 1'b1, 32'd0);    check("word2_reverted");
      drive(32'd28, 1'bx, 1'b0, 32'hFFFF_FFFF); tick();
      drive(32'd28, 1'b0, 1'b1, 32'd0);   check("x_write_ignored");

      for (int c = 0; c < 1000; c++) begin
         a = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 63)) : $urandom();
         drive(a, ($urandom_range(0, 2) == 0), ($urandom_range(0, 3) != 0), $urandom());
         if ($urandom_range(0, 63) == 0) begin
            rst = 1'b0;
            model_reset();
            #1;
         end else if (rst !== 1'b1) begin
            rst = 1'b1;
            #1;
         end
         check("rand_pre_edge");
         tick();
         check("rand_post_edge");
      end

      #5;
      if (exp_q.size() != 0) begin
         n_tests++;
         n_fail++;
         $display("FAIL scoreboard_drain: pending=%0d required=0", exp_q.size());
      end
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
